// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan path: segment encoding,
// hex glyph table and the index-width helper.
package seg_pkg;

  typedef logic [6:0] seg_t;

  // Active-high {g,f,e,d,c,b,a}; SEG_OFF means no segment lit.
  localparam seg_t SEG_OFF = 7'h00;

  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bits needed to hold values 0..n-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      w = w + 1;
    end
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-high seven-segment glyph lookup (purely combinational).
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_c_o
);

  assign seg_c_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit time-multiplexed seven-segment scanner with dwell prescaler, blanking gap and
// frame-synchronous data update. Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_HZ         = 27000000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]     blank_i,
  input  logic                      load_i,
  output logic [6:0]                seg_o,
  output logic [NUM_DIGITS-1:0]     an_o,
  output logic                      frame_o
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CW  = clog2(DIV);
  localparam int unsigned IW  = clog2(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam seg_t                  SEG_POL = {7{SEG_ACTIVE_LOW}};

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]    pend_q, pend_d;
  logic [NUM_DIGITS-1:0][3:0]    disp_q, disp_d;
  logic                          pend_v_q, pend_v_d;
  logic [NUM_DIGITS-1:0]         an_q, an_d;
  seg_t                          seg_q, seg_d;
  logic                          frame_q, frame_d;

  logic                          tick_c, wrap_c;
  logic [NUM_DIGITS-1:0]         lzb_c, mask_c, an_on_c;
  logic [3:0]                    nib_c;
  seg_t                          glyph_c;

`ifdef SEG_SCAN_LZB_EN
  // Digit k>0 is suppressed while it and all more significant digits are zero.
  always_comb begin
    logic zero_run;
    lzb_c    = '0;
    zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
      zero_run = zero_run & (disp_q[k] == 4'h0);
      lzb_c[k] = zero_run;
    end
  end
`else
  assign lzb_c = '0;
`endif

  assign mask_c = blank_i | lzb_c;
  assign nib_c  = disp_q[idx_q];

  seg_decoder u_dec (
    .nib_i   (nib_c),
    .seg_c_o (glyph_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    tick_c   = (cnt_q == CW'(DIV - 1));
    wrap_c   = tick_c && (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d    = tick_c ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;
    an_on_c  = '0;

    if (tick_c) idx_d = wrap_c ? '0 : idx_q + IW'(1);

    if (load_i) begin
      pend_d   = digits_i;
      pend_v_d = 1'b1;
    end

    // A load on the wrap tick bypasses the shadow and lands in this frame boundary.
    if (wrap_c) begin
      if (load_i) begin
        disp_d   = digits_i;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        disp_d   = pend_q;
        pend_v_d = 1'b0;
      end
    end

    if ((cnt_q >= CW'(BLANK_CYCLES)) && !mask_c[idx_q]) an_on_c[idx_q] = 1'b1;

    an_d    = an_on_c ^ AN_POL;
    seg_d   = ((|an_on_c) ? glyph_c : SEG_OFF) ^ SEG_POL;
    frame_d = wrap_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      disp_q   <= '0;
      an_q     <= AN_POL;
      seg_q    <= SEG_OFF ^ SEG_POL;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      disp_q   <= disp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, DIV=10, 2 blank cycles, both polarities active-low).
module tb_seg_scan_ctrl;

`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_i;
  logic [3:0]  blank_i;
  logic        load_i;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int vectors = 0;
  int errors  = 0;
  int n       = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS     (4),
    .CLK_HZ         (10000),
    .SCAN_HZ        (1000),
    .BLANK_CYCLES   (2),
    .AN_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits_i (digits_i),
    .blank_i  (blank_i),
    .load_i   (load_i),
    .seg_o    (seg_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to `target` rising edges after the last reset release, sampling 1 time unit later.
  task automatic go(input int target);
    while (n < target) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int frames;
    int multi_on;
    int blank_bad;

    rst_n    = 1'b0;
    load_i   = 1'b0;
    digits_i = 16'h0000;
    blank_i  = 4'h0;
    #12;
    chk("rst_an", 32'(an_o), 32'hF);
    chk("rst_seg", 32'(seg_o), 32'h7F);
    chk("rst_frame", 32'(frame_o), 32'h0);

    // Release with a load of 1234 pending for the first wrap.
    rst_n    = 1'b1;
    load_i   = 1'b1;
    digits_i = 16'h1234;
    n        = 0;
    go(1);
    load_i = 1'b0;
    chk("t1_blank0_an", 32'(an_o), 32'hF);
    chk("t1_blank0_seg", 32'(seg_o), 32'h7F);
    go(2);
    chk("t1_blank1_an", 32'(an_o), 32'hF);
    go(3);
    chk("t1_d0_an", 32'(an_o), 32'hE);
    chk("t1_d0_seg_old", 32'(seg_o), 32'h40);
    go(13);
    chk("t1_d1_an", 32'(an_o), LZB ? 32'hF : 32'hD);
    go(23);
    chk("t1_d2_an", 32'(an_o), LZB ? 32'hF : 32'hB);
    go(33);
    chk("t1_d3_an", 32'(an_o), LZB ? 32'hF : 32'h7);
    go(39);
    chk("t1_frame_pre", 32'(frame_o), 32'h0);
    go(40);
    chk("t1_frame", 32'(frame_o), 32'h1);
    chk("t1_d3_last_an", 32'(an_o), LZB ? 32'hF : 32'h7);
    go(41);
    chk("t1_frame_post", 32'(frame_o), 32'h0);
    chk("t1_gap_an", 32'(an_o), 32'hF);
    go(43);
    chk("t1_new_d0_an", 32'(an_o), 32'hE);
    chk("t1_new_d0_seg", 32'(seg_o), 32'h19);
    go(53);
    chk("t2_d1_an", 32'(an_o), 32'hD);
    chk("t2_d1_seg", 32'(seg_o), 32'h30);
    go(63);
    chk("t2_d2_an", 32'(an_o), 32'hB);
    chk("t2_d2_seg", 32'(seg_o), 32'h24);
    go(73);
    chk("t2_d3_an", 32'(an_o), 32'h7);
    chk("t2_d3_seg", 32'(seg_o), 32'h79);
    go(80);
    chk("t2_frame", 32'(frame_o), 32'h1);

    // One full frame of free run: exactly one frame pulse, never two anodes on.
    frames   = 0;
    multi_on = 0;
    for (int i = 81; i <= 120; i++) begin
      go(i);
      if (frame_o) frames++;
      if ($countones(~an_o) > 1) multi_on++;
    end
    chk("t2_frame_count", 32'(frames), 32'd1);
    chk("t2_one_hot", 32'(multi_on), 32'd0);

    // Load ABCD while digit 1 is being scanned.
    go(131);
    load_i   = 1'b1;
    digits_i = 16'hABCD;
    go(132);
    load_i = 1'b0;
    go(133);
    chk("t3_d1_old_seg", 32'(seg_o), 32'h30);
    go(143);
    chk("t3_d2_old_seg", 32'(seg_o), 32'h24);
    go(153);
    chk("t3_d3_old_seg", 32'(seg_o), 32'h79);
    go(160);
    chk("t3_frame", 32'(frame_o), 32'h1);
    go(163);
    chk("t3_d0_new_seg", 32'(seg_o), 32'h21);
    go(173);
    chk("t3_d1_new_seg", 32'(seg_o), 32'h46);

    // Two loads in one frame: last one wins.
    go(175);
    load_i   = 1'b1;
    digits_i = 16'h1111;
    go(176);
    load_i = 1'b0;
    go(185);
    load_i   = 1'b1;
    digits_i = 16'h2222;
    go(186);
    load_i = 1'b0;
    chk("t4_still_abcd_d2", 32'(seg_o), 32'h03);
    go(203);
    chk("t4_last_wins_d0", 32'(seg_o), 32'h24);
    go(233);
    chk("t4_last_wins_d3", 32'(seg_o), 32'h24);

    // Load coinciding with the wrap tick goes straight to the display.
    go(239);
    load_i   = 1'b1;
    digits_i = 16'h9876;
    go(240);
    load_i = 1'b0;
    go(243);
    chk("t4_coinc_d0", 32'(seg_o), 32'h02);
    go(253);
    chk("t4_coinc_d1", 32'(seg_o), 32'h78);
    go(283);
    chk("t4_coinc_hold", 32'(seg_o), 32'h02);

    // Mask digit 2 for a whole slot.
    blank_i = 4'b0100;
    go(293);
    chk("t5_d1_an", 32'(an_o), 32'hD);
    chk("t5_d1_seg", 32'(seg_o), 32'h78);
    blank_bad = 0;
    for (int i = 301; i <= 310; i++) begin
      go(i);
      if (an_o !== 4'hF || seg_o !== 7'h7F) blank_bad++;
    end
    chk("t5_d2_blanked", 32'(blank_bad), 32'd0);
    go(313);
    chk("t5_d3_an", 32'(an_o), 32'h7);
    chk("t5_d3_seg", 32'(seg_o), 32'h10);
    blank_i = 4'h0;

    // Queue a load, then reset mid-slot: pending data must be dropped.
    load_i   = 1'b1;
    digits_i = 16'hFFFF;
    go(314);
    load_i = 1'b0;
    go(315);
    chk("t6_pre_rst_an", 32'(an_o), 32'h7);
    rst_n = 1'b0;
    #1;
    chk("t6_async_an", 32'(an_o), 32'hF);
    chk("t6_async_seg", 32'(seg_o), 32'h7F);
    chk("t6_async_frame", 32'(frame_o), 32'h0);
    @(posedge clk);
    #1;
    chk("t6_held_an", 32'(an_o), 32'hF);
    rst_n = 1'b1;
    n     = 0;
    go(1);
    chk("t6_rel_blank_an", 32'(an_o), 32'hF);
    go(3);
    chk("t6_rel_d0_an", 32'(an_o), 32'hE);
    chk("t6_rel_d0_seg", 32'(seg_o), 32'h40);
    go(40);
    chk("t6_rel_frame", 32'(frame_o), 32'h1);
    go(43);
    chk("t6_pend_lost", 32'(seg_o), 32'h40);

    // 0050: leading zeros suppressed only when the option is built in.
    load_i   = 1'b1;
    digits_i = 16'h0050;
    go(44);
    load_i = 1'b0;
    go(83);
    chk("t7_d0_an", 32'(an_o), 32'hE);
    chk("t7_d0_seg", 32'(seg_o), 32'h40);
    go(93);
    chk("t7_d1_an", 32'(an_o), 32'hD);
    chk("t7_d1_seg", 32'(seg_o), 32'h12);
    go(103);
    chk("t7_d2_an", 32'(an_o), LZB ? 32'hF : 32'hB);
    chk("t7_d2_seg", 32'(seg_o), LZB ? 32'h7F : 32'h40);
    go(113);
    chk("t7_d3_an", 32'(an_o), LZB ? 32'hF : 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
